branch_dispatch: RTL and testbench

- Producer side of the branch reservation-station interface. Accepts decoded branch instructions from the decoder into a small operand-snooping queue.
- Obtains a ROB tag for the queue head and drives one entry per cycle toward the branch unit's reservation entries.
- Tracks free reservation entries with a credit counter, so the branch unit's insert never drops an entry.

---
 rtl/branch_dispatch_pkg.sv | 45 ++++
 rtl/branch_dispatch_if.sv | 45 ++++
 rtl/branch_dispatch_queue.sv | 72 +++++++
 rtl/branch_dispatch.sv | 122 ++++++++++++
 tb/tb_branch_dispatch.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_dispatch_pkg.sv
// Shared types and constants for the branch dispatch path: tag/op encodings,
// the queued branch entry and the broadcast snoop helper.
package branch_dispatch_pkg;
    localparam int DATA_W = 32;
    localparam int TAG_W  = 5;
    localparam int OP_W   = 4;

    localparam logic [TAG_W-1:0] TAG_INVALID = '1;

    localparam logic [OP_W-1:0] OP_BEQ  = 4'd0;
    localparam logic [OP_W-1:0] OP_BNE  = 4'd1;
    localparam logic [OP_W-1:0] OP_BLT  = 4'd4;
    localparam logic [OP_W-1:0] OP_BGE  = 4'd5;
    localparam logic [OP_W-1:0] OP_BLTU = 4'd6;
    localparam logic [OP_W-1:0] OP_BGEU = 4'd7;

    typedef struct packed {
        logic                     valid;
        logic [OP_W-1:0]          op;
        logic [DATA_W-1:0]        pc;
        logic [DATA_W-1:0]        offset;
        logic [1:2][DATA_W-1:0]   val;
        logic [1:2][TAG_W-1:0]    tag;
    } branch_dispatch_entry;

    // A broadcast on TAG_INVALID must never overwrite an already-valid operand.
    function automatic branch_dispatch_entry snoop_entry(
        input branch_dispatch_entry e,
        input logic                 bv,
        input logic [TAG_W-1:0]     bt,
        input logic [DATA_W-1:0]    bval
    );
        branch_dispatch_entry r;
        r = e;
        if (e.valid && bv && bt != TAG_INVALID && e.tag[1] == bt) begin
            r.val[1] = bval;
            r.tag[1] = TAG_INVALID;
        end
        if (e.valid && bv && bt != TAG_INVALID && e.tag[2] == bt) begin
            r.val[2] = bval;
            r.tag[2] = TAG_INVALID;
        end
        return r;
    endfunction
endpackage

// File: rtl/branch_dispatch_if.sv
// Decoder / broadcast / ROB / branch-unit signals of the branch dispatch stage.
interface branch_dispatch_if;
    import branch_dispatch_pkg::*;

    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   in_op;
    logic [DATA_W-1:0] in_pc;
    logic [DATA_W-1:0] in_offset;
    logic [DATA_W-1:0] in_val1;
    logic [DATA_W-1:0] in_val2;
    logic [TAG_W-1:0]  in_tag1;
    logic [TAG_W-1:0]  in_tag2;
    logic              bcast_valid;
    logic [TAG_W-1:0]  bcast_tag;
    logic [DATA_W-1:0] bcast_val;
    logic              rob_alloc_req;
    logic              rob_alloc_gnt;
    logic [TAG_W-1:0]  rob_alloc_tag;
    logic [TAG_W-1:0]  rs_issue_tag;
    logic [TAG_W-1:0]  rs_target;
    logic [DATA_W-1:0] rs_val1;
    logic [DATA_W-1:0] rs_val2;
    logic [TAG_W-1:0]  rs_tag1;
    logic [TAG_W-1:0]  rs_tag2;
    logic [DATA_W-1:0] rs_pc;
    logic [DATA_W-1:0] rs_offset;
    logic [OP_W-1:0]   rs_op;
    logic [2:0]        credits;

    modport master (
        input  flush, in_valid, in_op, in_pc, in_offset, in_val1, in_val2, in_tag1, in_tag2,
               bcast_valid, bcast_tag, bcast_val, rob_alloc_gnt, rob_alloc_tag, rs_issue_tag,
        output in_ready, rob_alloc_req, rs_target, rs_val1, rs_val2, rs_tag1, rs_tag2,
               rs_pc, rs_offset, rs_op, credits
    );

    modport slave (
        output flush, in_valid, in_op, in_pc, in_offset, in_val1, in_val2, in_tag1, in_tag2,
               bcast_valid, bcast_tag, bcast_val, rob_alloc_gnt, rob_alloc_tag, rs_issue_tag,
        input  in_ready, rob_alloc_req, rs_target, rs_val1, rs_val2, rs_tag1, rs_tag2,
               rs_pc, rs_offset, rs_op, credits
    );
endinterface

// File: rtl/branch_dispatch_queue.sv
// Circular queue of pending branches; every stored entry snoops the result
// broadcast each cycle, and the push path applies the same-cycle broadcast.
module branch_dispatch_queue
    import branch_dispatch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 push,
    input  logic                 pop,
    input  branch_dispatch_entry push_entry,
    input  logic                 bcast_valid,
    input  logic [TAG_W-1:0]     bcast_tag,
    input  logic [DATA_W-1:0]    bcast_val,
    output branch_dispatch_entry head,
    output logic                 empty,
    output logic                 full
);
    localparam int PTR_W = $clog2(DEPTH) + 1;

    branch_dispatch_entry mem_q [DEPTH];
    branch_dispatch_entry mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                   (wr_ptr_q[PTR_W-2:0] == rd_ptr_q[PTR_W-2:0]);
    assign head  = snoop_entry(mem_q[rd_ptr_q[PTR_W-2:0]], bcast_valid, bcast_tag, bcast_val);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = snoop_entry(mem_q[i], bcast_valid, bcast_tag, bcast_val);
        end
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i].valid = 1'b0;
            end
        end else begin
            if (pop) begin
                mem_d[rd_ptr_q[PTR_W-2:0]].valid = 1'b0;
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push) begin
                mem_d[wr_ptr_q[PTR_W-2:0]] = snoop_entry(push_entry, bcast_valid, bcast_tag, bcast_val);
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end
endmodule

// File: rtl/branch_dispatch.sv
// Branch dispatch stage: queues decoded branches, pairs the head with a ROB tag
// and sends one entry per cycle to the branch unit under a credit limit.
module branch_dispatch
    import branch_dispatch_pkg::*;
#(
    parameter int QUEUE_DEPTH = 4,
    parameter int RS_CREDITS  = 4
) (
    input  logic                clk,
    input  logic                rst,
    branch_dispatch_if.master   bus
);
    localparam logic [2:0] CREDITS_MAX = 3'(RS_CREDITS);

    branch_dispatch_entry push_entry, q_head;
    logic q_empty, q_full, push, dispatch, credit_ret, credit_overflow;

    logic [2:0]             credits_q, credits_d;
    logic [TAG_W-1:0]       rs_target_q, rs_target_d;
    logic [OP_W-1:0]        rs_op_q, rs_op_d;
    logic [DATA_W-1:0]      rs_pc_q, rs_pc_d;
    logic [DATA_W-1:0]      rs_offset_q, rs_offset_d;
    logic [1:2][DATA_W-1:0] rs_val_q, rs_val_d;
    logic [1:2][TAG_W-1:0]  rs_tag_q, rs_tag_d;

    always_comb begin
        push_entry        = '0;
        push_entry.valid  = 1'b1;
        push_entry.op     = bus.in_op;
        push_entry.pc     = bus.in_pc;
        push_entry.offset = bus.in_offset;
        push_entry.val[1] = bus.in_val1;
        push_entry.val[2] = bus.in_val2;
        push_entry.tag[1] = bus.in_tag1;
        push_entry.tag[2] = bus.in_tag2;
    end

    // No pop-to-ready bypass: a full queue refuses input even while popping.
    assign bus.in_ready      = !q_full;
    assign push              = bus.in_valid && !q_full && !bus.flush;
    assign bus.rob_alloc_req = !q_empty && (credits_q != 3'd0) && !bus.flush;
    assign dispatch          = bus.rob_alloc_req && bus.rob_alloc_gnt;
    assign credit_ret        = (bus.rs_issue_tag != TAG_INVALID);
    assign credit_overflow   = credit_ret && !dispatch && !bus.flush && (credits_q == CREDITS_MAX);

    branch_dispatch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
        .clk         (clk),
        .rst         (rst),
        .flush       (bus.flush),
        .push        (push),
        .pop         (dispatch),
        .push_entry  (push_entry),
        .bcast_valid (bus.bcast_valid),
        .bcast_tag   (bus.bcast_tag),
        .bcast_val   (bus.bcast_val),
        .head        (q_head),
        .empty       (q_empty),
        .full        (q_full)
    );

    always_comb begin
        credits_d = credits_q;
        if (bus.flush) begin
            credits_d = CREDITS_MAX;
        end else if (dispatch && !credit_ret) begin
            credits_d = credits_q - 3'd1;
        end else if (credit_ret && !dispatch && !credit_overflow) begin
            credits_d = credits_q + 3'd1;
        end
    end

    always_comb begin
        rs_target_d = TAG_INVALID;
        rs_op_d     = rs_op_q;
        rs_pc_d     = rs_pc_q;
        rs_offset_d = rs_offset_q;
        rs_val_d    = rs_val_q;
        rs_tag_d    = rs_tag_q;
        if (dispatch) begin
            rs_target_d = bus.rob_alloc_tag;
            rs_op_d     = q_head.op;
            rs_pc_d     = q_head.pc;
            rs_offset_d = q_head.offset;
            rs_val_d    = q_head.val;
            rs_tag_d    = q_head.tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits_q   <= CREDITS_MAX;
            rs_target_q <= TAG_INVALID;
            rs_op_q     <= '0;
            rs_pc_q     <= '0;
            rs_offset_q <= '0;
            rs_val_q    <= '0;
            rs_tag_q    <= '0;
        end else begin
            credits_q   <= credits_d;
            rs_target_q <= rs_target_d;
            rs_op_q     <= rs_op_d;
            rs_pc_q     <= rs_pc_d;
            rs_offset_q <= rs_offset_d;
            rs_val_q    <= rs_val_d;
            rs_tag_q    <= rs_tag_d;
        end
    end

    assign bus.credits   = credits_q;
    assign bus.rs_target = rs_target_q;
    assign bus.rs_op     = rs_op_q;
    assign bus.rs_pc     = rs_pc_q;
    assign bus.rs_offset = rs_offset_q;
    assign bus.rs_val1   = rs_val_q[1];
    assign bus.rs_val2   = rs_val_q[2];
    assign bus.rs_tag1   = rs_tag_q[1];
    assign bus.rs_tag2   = rs_tag_q[2];

    // The branch unit must never return more credits than it was given.
    a_credit_overflow: assert property (@(posedge clk) disable iff (rst) !credit_overflow);
    a_head_valid:      assert property (@(posedge clk) disable iff (rst) !q_empty |-> q_head.valid);
endmodule

// File: tb/tb_branch_dispatch.sv
// Scoreboard bench for branch_dispatch: a queue-level reference model predicts
// each branch-unit entry, a negedge monitor compares every rs_target pulse.
module tb_branch_dispatch;
    import branch_dispatch_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_dispatch_if bus ();
    branch_dispatch #(.QUEUE_DEPTH(4), .RS_CREDITS(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [TAG_W-1:0]     target;
        branch_dispatch_entry e;
    } exp_t;

    exp_t                 exp_q [$];
    branch_dispatch_entry model_q [$];
    int                   model_credits = 4;
    int                   checks = 0;
    int                   errors = 0;
    exp_t                 mon_x;
    logic [OP_W-1:0]      ops [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic branch_dispatch_entry apply_bcast(input branch_dispatch_entry e);
        branch_dispatch_entry r;
        r = e;
        if (bus.bcast_valid && bus.bcast_tag != TAG_INVALID) begin
            if (e.tag[1] == bus.bcast_tag) begin r.val[1] = bus.bcast_val; r.tag[1] = TAG_INVALID; end
            if (e.tag[2] == bus.bcast_tag) begin r.val[2] = bus.bcast_val; r.tag[2] = TAG_INVALID; end
        end
        return r;
    endfunction

    task automatic idle();
        bus.flush         = 1'b0;
        bus.in_valid      = 1'b0;
        bus.bcast_valid   = 1'b0;
        bus.bcast_tag     = TAG_INVALID;
        bus.bcast_val     = '0;
        bus.rob_alloc_gnt = 1'b0;
        bus.rob_alloc_tag = '0;
        bus.rs_issue_tag  = TAG_INVALID;
    endtask

    task automatic set_in(input logic [OP_W-1:0] op, input logic [31:0] pc, input logic [31:0] off,
                          input logic [31:0] v1, input logic [31:0] v2,
                          input logic [TAG_W-1:0] t1, input logic [TAG_W-1:0] t2);
        bus.in_op = op; bus.in_pc = pc; bus.in_offset = off;
        bus.in_val1 = v1; bus.in_val2 = v2; bus.in_tag1 = t1; bus.in_tag2 = t2;
    endtask

    // Predict the coming posedge from the current inputs, then advance to it.
    task automatic tick();
        branch_dispatch_entry e;
        exp_t x;
        bit acc, disp, ret;
        #1;
        check("in_ready", bus.in_ready, model_q.size() < 4);
        check("rob_alloc_req", bus.rob_alloc_req, model_q.size() > 0 && model_credits > 0 && !bus.flush);
        ret = (bus.rs_issue_tag != TAG_INVALID);
        if (bus.flush) begin
            model_q.delete();
            model_credits = 4;
        end else begin
            acc  = bus.in_valid && model_q.size() < 4;
            disp = model_q.size() > 0 && model_credits > 0 && bus.rob_alloc_gnt;
            foreach (model_q[i]) model_q[i] = apply_bcast(model_q[i]);
            if (disp) begin
                x.target = bus.rob_alloc_tag;
                x.e = model_q.pop_front();
                exp_q.push_back(x);
                model_credits--;
            end
            if (acc) begin
                e = '0;
                e.valid = 1'b1; e.op = bus.in_op; e.pc = bus.in_pc; e.offset = bus.in_offset;
                e.val[1] = bus.in_val1; e.val[2] = bus.in_val2;
                e.tag[1] = bus.in_tag1; e.tag[2] = bus.in_tag2;
                model_q.push_back(apply_bcast(e));
            end
            if (ret) model_credits++;
        end
        @(posedge clk);
    endtask

    task automatic cycle();
        tick();
        @(negedge clk);
        check("credits", bus.credits, model_credits);
    endtask

    task automatic drain();
        bus.in_valid = 1'b0;
        bus.bcast_valid = 1'b0;
        bus.flush = 1'b0;
        for (int i = 0; i < 14; i++) begin
            bus.rob_alloc_gnt = 1'b1;
            bus.rob_alloc_tag = 5'(i);
            bus.rs_issue_tag  = (model_credits < 4) ? 5'(i) : TAG_INVALID;
            cycle();
        end
        idle();
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rs_target !== TAG_INVALID) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rs_pulse: got rs_target %0h, expected no dispatch", bus.rs_target);
                end else begin
                    mon_x = exp_q.pop_front();
                    check("rs_target", bus.rs_target, mon_x.target);
                    check("rs_op", bus.rs_op, mon_x.e.op);
                    check("rs_pc", bus.rs_pc, mon_x.e.pc);
                    check("rs_offset", bus.rs_offset, mon_x.e.offset);
                    check("rs_val1", bus.rs_val1, mon_x.e.val[1]);
                    check("rs_val2", bus.rs_val2, mon_x.e.val[2]);
                    check("rs_tag1", bus.rs_tag1, mon_x.e.tag[1]);
                    check("rs_tag2", bus.rs_tag2, mon_x.e.tag[2]);
                end
            end else if (exp_q.size() != 0) begin
                checks++;
                errors++;
                $display("FAIL rs_missing: got no dispatch, expected rs_target %0h", exp_q[0].target);
                exp_q.delete();
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        ops = '{OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU};
        rst = 1'b1;
        idle();
        set_in(OP_BEQ, 0, 0, 0, 0, TAG_INVALID, TAG_INVALID);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_rs_target", bus.rs_target, TAG_INVALID);
        check("rst_rs_val1", bus.rs_val1, 0);
        check("rst_rs_pc", bus.rs_pc, 0);
        check("rst_credits", bus.credits, 4);
        check("rst_in_ready", bus.in_ready, 1);

        // 1: ready operands
        set_in(OP_BEQ, 32'h100, 32'h20, 5, 5, TAG_INVALID, TAG_INVALID);
        bus.in_valid = 1'b1;
        cycle();
        idle();
        bus.rob_alloc_gnt = 1'b1; bus.rob_alloc_tag = 5'd3;
        cycle();
        check("t1_target", bus.rs_target, 3);
        check("t1_val1", bus.rs_val1, 5);
        check("t1_val2", bus.rs_val2, 5);
        check("t1_pc", bus.rs_pc, 32'h100);
        check("t1_offset", bus.rs_offset, 32'h20);
        idle();
        cycle();
        check("t1_pulse_end", bus.rs_target, TAG_INVALID);
        check("t1_credits", bus.credits, 3);
        bus.rs_issue_tag = 5'd3;
        cycle();
        idle();

        // 2: credit exhaustion
        bus.rob_alloc_gnt = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_in(OP_BNE, 32'h200 + 32'(4 * i), 32'h8, 32'(i), 32'(i + 1), TAG_INVALID, TAG_INVALID);
            bus.in_valid = 1'b1;
            bus.rob_alloc_tag = 5'(10 + i);
            cycle();
        end
        bus.in_valid = 1'b0;
        repeat (3) cycle();
        check("t2_req_low", bus.rob_alloc_req, 0);
        check("t2_credits0", bus.credits, 0);
        bus.rs_issue_tag = 5'd2;
        cycle();
        bus.rs_issue_tag = TAG_INVALID;
        bus.rob_alloc_tag = 5'd20;
        cycle();
        check("t2_fifth", bus.rs_target, 20);
        check("t2_credits_end", bus.credits, 0);
        drain();

        // 3: queued snoop
        set_in(OP_BLT, 32'h300, 32'h40, 32'h1, 32'h2, 5'd7, TAG_INVALID);
        bus.in_valid = 1'b1;
        cycle();
        idle();
        cycle();
        bus.bcast_valid = 1'b1; bus.bcast_tag = 5'd7; bus.bcast_val = 32'h55;
        cycle();
        idle();
        bus.rob_alloc_gnt = 1'b1; bus.rob_alloc_tag = 5'd4;
        cycle();
        check("t3_tag1", bus.rs_tag1, TAG_INVALID);
        check("t3_val1", bus.rs_val1, 32'h55);
        drain();

        // 4: capture bypass
        set_in(OP_BGE, 32'h400, 32'h10, 32'h3, 32'h4, TAG_INVALID, 5'd9);
        bus.in_valid = 1'b1;
        bus.bcast_valid = 1'b1; bus.bcast_tag = 5'd9; bus.bcast_val = 32'hAA;
        cycle();
        idle();
        bus.rob_alloc_gnt = 1'b1; bus.rob_alloc_tag = 5'd6;
        cycle();
        check("t4_tag2", bus.rs_tag2, TAG_INVALID);
        check("t4_val2", bus.rs_val2, 32'hAA);
        drain();

        // 5: full queue with no credits
        bus.rob_alloc_gnt = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_in(OP_BLTU, 32'h500 + 32'(i), 32'h4, 32'(i), 32'(i), TAG_INVALID, TAG_INVALID);
            bus.in_valid = (i != 4);
            bus.rob_alloc_tag = 5'(i);
            cycle();
        end
        set_in(OP_BGEU, 32'h5FF, 32'h4, 32'h9, 32'h9, TAG_INVALID, TAG_INVALID);
        bus.in_valid = 1'b1;
        cycle();
        check("t5_full", bus.in_ready, 0);
        bus.rs_issue_tag = 5'd1;
        cycle();
        bus.rs_issue_tag = TAG_INVALID;
        cycle();
        check("t5_ready_after_pop", bus.in_ready, 1);
        cycle();
        drain();

        // 6: flush with 3 queued and one credit, then reset mid-dispatch
        bus.rob_alloc_gnt = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_in(OP_BNE, 32'h600 + 32'(i), 32'h4, 32'(i), 32'(i), 5'd12, TAG_INVALID);
            bus.in_valid = (i != 3);
            bus.rob_alloc_gnt = (i < 4);
            cycle();
        end
        bus.in_valid = 1'b1;
        cycle();
        bus.flush = 1'b1; bus.rob_alloc_gnt = 1'b1; bus.rs_issue_tag = 5'd0;
        cycle();
        check("t6_credits", bus.credits, 4);
        idle();
        cycle();
        check("t6_empty_req", bus.rob_alloc_req, 0);
        bus.in_valid = 1'b1;
        cycle();
        idle();
        bus.rob_alloc_gnt = 1'b1; bus.rob_alloc_tag = 5'd8;
        tick();
        #1;
        check("t6_pulse", bus.rs_target, 8);
        rst = 1'b1;
        #1;
        check("t6_rst_target", bus.rs_target, TAG_INVALID);
        check("t6_rst_credits", bus.credits, 4);
        exp_q.delete();
        model_q.delete();
        model_credits = 4;
        idle();
        @(negedge clk);
        rst = 1'b0;

        // random traffic
        for (int n = 0; n < 1500; n++) begin
            set_in(ops[$urandom_range(0, 5)], $urandom, $urandom, $urandom, $urandom,
                   ($urandom_range(0, 1) == 1) ? TAG_INVALID : 5'($urandom_range(1, 6)),
                   ($urandom_range(0, 1) == 1) ? TAG_INVALID : 5'($urandom_range(1, 6)));
            bus.in_valid      = ($urandom_range(0, 99) < 60);
            bus.bcast_valid   = ($urandom_range(0, 1) == 1);
            bus.bcast_tag     = 5'($urandom_range(1, 6));
            bus.bcast_val     = $urandom;
            bus.rob_alloc_gnt = ($urandom_range(0, 99) < 70);
            bus.rob_alloc_tag = 5'($urandom_range(0, 30));
            bus.rs_issue_tag  = (model_credits < 4 && $urandom_range(0, 99) < 40) ?
                                5'($urandom_range(0, 30)) : TAG_INVALID;
            bus.flush         = ($urandom_range(0, 99) < 3);
            cycle();
        end
        drain();
        repeat (2) cycle();
        check("scoreboard_empty", exp_q.size(), 0);
        check("model_empty_req", bus.rob_alloc_req, model_q.size() > 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
